// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// data-memory wait states, saturating perf counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int CNT_BITWIDTH     = 16,
  parameter int MEM_TIMEOUT      = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
  input  logic                        id_useRs1,
  input  logic                        id_useRs2,
  input  logic                        ex_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite,
  input  logic                        PCSrc,
  input  logic                        mem_memRead,
  input  logic                        mem_memWrite,
  input  logic                        dmem_ready,
  output logic                        pc_write,
  output logic                        pc_sel_branch,
  output logic                        if_id_write,
  output logic                        id_ex_write,
  output logic                        ex_mem_write,
  output logic                        if_id_flush,
  output logic                        id_ex_flush,
  output logic                        ex_mem_flush,
  output logic                        mem_wb_bubble,
  output logic [1:0]                  state,
  output logic [CNT_BITWIDTH-1:0]     stall_cnt,
  output logic [CNT_BITWIDTH-1:0]     flush_cnt,
  output logic                        mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              memwait, hazard, stall_mem, flush_evt, timeout_hit;

  assign state   = cur;
  assign memwait = (mem_memRead | mem_memWrite) & ~dmem_ready;
  assign hazard  = ex_memRead & (ex_regToWrite != '0) &
                   ((id_useRs1 & (id_rs1 == ex_regToWrite)) |
                    (id_useRs2 & (id_rs2 == ex_regToWrite)));

  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    nxt           = cur;
    wait_nxt      = wait_cnt;
    stall_mem     = 1'b0;
    flush_evt     = 1'b0;
    timeout_hit   = 1'b0;

    case (cur)
      RUN: begin
        if (memwait) begin
          stall_mem = 1'b1;
          wait_nxt  = WAIT_W'(1);
          nxt       = MEM_WAIT;
        end else if (PCSrc) begin
          pc_sel_branch = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          ex_mem_flush  = 1'b1;
          flush_evt     = 1'b1;
          nxt           = FLUSH;
        end else if (hazard) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      FLUSH: begin
        if (memwait) begin
          stall_mem = 1'b1;
          wait_nxt  = WAIT_W'(1);
          nxt       = MEM_WAIT;
        end else begin
          nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          stall_mem = 1'b1;
          wait_nxt  = wait_cnt + WAIT_W'(1);
        end else begin
          wait_nxt = '0;
          nxt      = RUN;
        end
      end
      default: nxt = RUN;
    endcase

    // The cycle that brings the wait count up to the limit is the last stalled one.
    if (stall_mem && (wait_nxt >= WAIT_W'(MEM_TIMEOUT))) begin
      timeout_hit = 1'b1;
      wait_nxt    = '0;
      nxt         = RUN;
    end

    if (stall_mem) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end

    if (!rst_n) begin
      pc_write      = 1'b1;
      pc_sel_branch = 1'b0;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
      if (timeout_hit)
        mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-level behavioural model
// of the stall/flush rules, plus directed scenarios for the documented cases.
module tb_pipeline_hazard_ctrl;

  localparam int RNB = 5;
  localparam int CNB = 6;
  localparam int TO  = 4;
  localparam int SAT = (1 << CNB) - 1;

  localparam logic [8:0] DEF = 9'b1_0_111_000_0;
  localparam logic [8:0] STL = 9'b0_0_000_000_1;
  localparam logic [8:0] BRN = 9'b1_1_111_111_0;
  localparam logic [8:0] HAZ = 9'b0_0_011_010_0;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [RNB-1:0] id_rs1, id_rs2, ex_regToWrite;
  logic           id_useRs1, id_useRs2, ex_memRead, PCSrc;
  logic           mem_memRead, mem_memWrite, dmem_ready;
  logic           pc_write, pc_sel_branch, if_id_write, id_ex_write, ex_mem_write;
  logic           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble;
  logic [1:0]     state;
  logic [CNB-1:0] stall_cnt, flush_cnt;
  logic           mem_timeout;
  logic [8:0]     ctl;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: how many consecutive wait cycles so far, and whether the previous cycle flushed
  int wait_cycles, exp_stall, exp_flush;
  bit just_flushed, exp_to;

  pipeline_hazard_ctrl #(
    .REG_NUM_BITWIDTH(RNB),
    .CNT_BITWIDTH(CNB),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_memRead(ex_memRead), .ex_regToWrite(ex_regToWrite),
    .PCSrc(PCSrc), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .if_id_write(if_id_write), .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_bubble(mem_wb_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  assign ctl = {pc_write, pc_sel_branch, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2,
                       input bit exr, input int exrd, input bit br,
                       input bit mr, input bit mw, input bit rdy);
    id_rs1        = RNB'(rs1);
    id_rs2        = RNB'(rs2);
    id_useRs1     = u1;
    id_useRs2     = u2;
    ex_memRead    = exr;
    ex_regToWrite = RNB'(exrd);
    PCSrc         = br;
    mem_memRead   = mr;
    mem_memWrite  = mw;
    dmem_ready    = rdy;
  endtask

  task automatic model_clear();
    wait_cycles  = 0;
    just_flushed = 0;
    exp_stall    = 0;
    exp_flush    = 0;
    exp_to       = 0;
  endtask

  // Enter reset asynchronously, check it took effect immediately, release after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_ctl", 32'(ctl), 32'(DEF));
    check("rst_state", 32'(state), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock with the currently driven inputs: check combinational controls, then registered state.
  task automatic cycle();
    bit         mw, hz;
    logic [8:0] exp_ctl;
    int         exp_state;
    #2;
    mw = (mem_memRead || mem_memWrite) && !dmem_ready;
    hz = ex_memRead && (ex_regToWrite != 0) &&
         ((id_useRs1 && id_rs1 == ex_regToWrite) || (id_useRs2 && id_rs2 == ex_regToWrite));
    if (wait_cycles > 0)   exp_ctl = dmem_ready ? DEF : STL;
    else if (just_flushed) exp_ctl = mw ? STL : DEF;
    else if (mw)           exp_ctl = STL;
    else if (PCSrc)        exp_ctl = BRN;
    else if (hz)           exp_ctl = HAZ;
    else                   exp_ctl = DEF;
    check("ctl", 32'(ctl), 32'(exp_ctl));

    if (exp_ctl[8] == 1'b0 && exp_stall < SAT) exp_stall++;
    if (exp_ctl == BRN && exp_flush < SAT) exp_flush++;
    just_flushed = (exp_ctl == BRN);
    if (exp_ctl == STL) begin
      wait_cycles++;
      if (wait_cycles >= TO) begin
        exp_to      = 1;
        wait_cycles = 0;
      end
    end else begin
      wait_cycles = 0;
    end
    exp_state = (wait_cycles > 0) ? 2 : (just_flushed ? 1 : 0);

    @(posedge clk);
    #1;
    check("state", 32'(state), 32'(exp_state));
    check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    check("mem_timeout", 32'(mem_timeout), 32'(exp_to));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // load-use on rs1
    drive(5, 7, 1, 0, 1, 5, 0, 0, 0, 1);
    cycle();
    check("t1_stall_cnt", 32'(stall_cnt), 1);
    drive(5, 7, 1, 0, 0, 9, 0, 0, 0, 1);
    cycle();

    // load into x0 never stalls
    drive(0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
    cycle();
    check("t2_stall_cnt", 32'(stall_cnt), 1);

    // taken branch, PCSrc left high through FLUSH
    drive(3, 4, 1, 1, 1, 3, 1, 0, 0, 1);
    cycle();
    check("t3_state_flush", 32'(state), 1);
    cycle();
    check("t3_flush_cnt", 32'(flush_cnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();

    // three-cycle memory wait
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) cycle();
    check("t4_stall_cnt", 32'(stall_cnt), 3);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cycle();
    check("t4_state_run", 32'(state), 0);

    // branch pending behind a memory wait
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    repeat (2) cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    cycle();
    check("t5_no_flush_yet", 32'(flush_cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    cycle();
    check("t5_flush_cnt", 32'(flush_cnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();

    // stuck memory -> timeout after TO wait cycles
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (TO) cycle();
    check("t6_timeout", 32'(mem_timeout), 1);
    check("t6_state_run", 32'(state), 0);
    cycle();
    do_reset();
    check("t6_cleared", 32'(mem_timeout), 0);

    // async reset in the middle of FLUSH
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    cycle();
    do_reset();

    // randomized traffic with occasional resets; counters saturate along the way
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 4), $urandom_range(0, 3), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1), ($urandom_range(0, 9) < 4));
      cycle();
      if (i % 700 == 699) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
